// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared constants and types for the fp32 multiplier arbiter.
//   FP32 field widths and bias, default requester count, the canonical quiet NaN,
//   and the result record carried from the multiplier core into the response register.
package fp_mul_pkg;

  localparam int FP32_W      = 32;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MAN_W  = 23;
  localparam int FP32_BIAS   = 127;
  localparam int DEF_NUM_REQ = 4;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

  // One multiplier result: product plus its exception flags.
  typedef struct packed {
    logic [FP32_W-1:0] data;
    logic              uflow;
    logic              oflow;
  } fp32_res_t;

endpackage

// File: rtl/fp32_mul_core.sv
// fp32_mul_core: single-cycle (combinational) IEEE-754 binary32 multiplier.
//   Round-to-nearest-even. Subnormal inputs are treated as zero and results below
//   the normal range flush to signed zero with uflow set. Results above the normal
//   range saturate to signed infinity with oflow set. NaN or inf*0 gives quiet NaN.
// Ports:
//   a, b  in  FP32_W    operands
//   res   out fp32_res_t product with uflow/oflow flags
module fp32_mul_core
  import fp_mul_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output fp32_res_t         res
);

  logic                  sign;
  logic [FP32_EXP_W-1:0] ea, eb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]           prod;
  logic [FP32_MAN_W-1:0] man;
  logic                  guard, sticky, round_up;
  logic [FP32_MAN_W:0]   man_rnd;
  logic signed [10:0]    exp_r;

  // NOTE: every variable assigned in this block is written on every path before
  // use, so no latch can be inferred; res gets its default first for the same reason.
  always_comb begin
    res      = '0;
    sign     = a[31] ^ b[31];
    ea       = a[30:23];
    eb       = b[30:23];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (a[22:0] == '0);
    b_inf    = (eb == '1) && (b[22:0] == '0);
    a_nan    = (ea == '1) && (a[22:0] != '0);
    b_nan    = (eb == '1) && (b[22:0] != '0);

    prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    // Product of two 1.x mantissas lies in [1,4): bit 47 selects the normalising shift.
    man      = prod[47] ? prod[46:24] : prod[45:23];
    guard    = prod[47] ? prod[23]    : prod[22];
    sticky   = prod[47] ? (|prod[22:0]) : (|prod[21:0]);
    round_up = guard & (sticky | man[0]);
    man_rnd  = {1'b0, man} + {{FP32_MAN_W{1'b0}}, round_up};

    exp_r    = 11'(ea) + 11'(eb) - 11'(FP32_BIAS) + 11'(prod[47]) + 11'(man_rnd[FP32_MAN_W]);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res.data = FP32_QNAN;
    end else if (a_inf || b_inf) begin
      res.data = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      res.data = {sign, 31'd0};
    end else if (exp_r >= 11'sd255) begin
      res.data  = {sign, 8'hFF, 23'd0};
      res.oflow = 1'b1;
    end else if (exp_r <= 11'sd0) begin
      res.data  = {sign, 31'd0};
      res.uflow = 1'b1;
    end else begin
      // A rounding carry leaves man_rnd[22:0] at zero, which is the correct mantissa.
      res.data = {sign, exp_r[7:0], man_rnd[FP32_MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one fp32_mul_core between NUM_REQ requesters.
//   Round-robin arbitration into a 2-stage pipeline (operand register -> result
//   register) with valid/ready on both sides; each result carries its requester ID.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-requester handshake (at most one ready bit high)
//   req_a, req_b          packed operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_ready   result handshake
//   rsp_id, rsp_data      requester index and fp32 product
//   rsp_uflow, rsp_oflow  core flags for this result
//   busy                  any operation in flight
//   op_count              results accepted downstream, wraps
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FP32_W-1:0]  req_a,
  input  logic [NUM_REQ*FP32_W-1:0]  req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [FP32_W-1:0]          rsp_data,
  output logic                       rsp_uflow,
  output logic                       rsp_oflow,
  output logic                       busy,
  output logic [CNT_W-1:0]           op_count
);

  // Returns {found, index}: first set bit of valid scanning ptr, ptr+1, ... mod NUM_REQ.
  // Scanning from the far end lets the closest candidate overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  logic                s1_valid, s2_valid;
  logic [FP32_W-1:0]   s1_a, s1_b;
  logic [ID_W-1:0]     s1_id;
  logic [ID_W-1:0]     rr_ptr;
  fp32_res_t           core_res, rsp_q;
  logic [ID_W-1:0]     rsp_id_q;

  logic [ID_W:0]       pick;
  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic                adv1, adv2, accept, handshake;

  assign adv2      = ~s2_valid | rsp_ready;
  assign adv1      = s1_valid & adv2;
  assign accept    = ~s1_valid | adv2;

  assign pick      = rr_pick(req_valid, rr_ptr);
  assign grant_any = pick[ID_W];
  assign grant_idx = pick[ID_W-1:0];

  // rst_n gates the combinational ready so nothing looks accepted while held in reset.
  assign req_ready = (grant_any & accept & rst_n) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign handshake = |(req_valid & req_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others (s1 can be reloaded while stage 2 reads it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (handshake) begin
      s1_valid <= 1'b1;
      rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: operand registers carry no reset: they are only observed behind s1_valid,
  // so clearing them would cost reset routing without changing behaviour.
  always_ff @(posedge clk) begin
    if (handshake) begin
      s1_a  <= req_a[FP32_W*grant_idx +: FP32_W];
      s1_b  <= req_b[FP32_W*grant_idx +: FP32_W];
      s1_id <= grant_idx;
    end
  end

  fp32_mul_core u_core (
    .a   (s1_a),
    .b   (s1_b),
    .res (core_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      rsp_q    <= '0;
      rsp_id_q <= '0;
    end else if (adv1) begin
      s2_valid <= 1'b1;
      rsp_q    <= core_res;
      rsp_id_q <= s1_id;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_valid & rsp_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_uflow = rsp_q.uflow;
  assign rsp_oflow = rsp_q.oflow;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed testbench for fp_mul_arbiter (NUM_REQ=4, CNT_W=4 so the counter wrap is reachable).
module tb_fp_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_a, req_b;
  logic                     rsp_valid, rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     rsp_uflow, rsp_oflow, busy;
  logic [CNT_W-1:0]         op_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  // Products of (i+1.0) * 2.0 for requester i in the streaming tests.
  logic [31:0] stream_a [NUM_REQ] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  logic [31:0] stream_p [NUM_REQ] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_uflow (rsp_uflow),
    .rsp_oflow (rsp_oflow),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on requester r; checks ready, 2-edge latency, result, count.
  task automatic do_single(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic eu, input logic eo);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_valid = 4'(1 << r);
    #1;
    chk($sformatf("single%0d_ready", r), 32'(req_ready), 32'(1 << r));
    tick();
    req_valid = '0;
    chk($sformatf("single%0d_lat1", r), 32'(rsp_valid), 32'd0);
    tick();
    chk($sformatf("single%0d_valid", r), 32'(rsp_valid), 32'd1);
    chk($sformatf("single%0d_id", r), 32'(rsp_id), 32'(r));
    chk($sformatf("single%0d_data", r), rsp_data, exp_d);
    chk($sformatf("single%0d_uflow", r), 32'(rsp_uflow), 32'(eu));
    chk($sformatf("single%0d_oflow", r), 32'(rsp_oflow), 32'(eo));
    chk($sformatf("single%0d_cnt_pre", r), 32'(op_count), 32'(exp_cnt));
    tick();
    exp_cnt++;
    chk($sformatf("single%0d_done", r), 32'(rsp_valid), 32'd0);
    chk($sformatf("single%0d_cnt", r), 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    exp_cnt   = '0;
    #12;
    // Reset state, with requests pending to show ready is held low.
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single operations; order leaves rr_ptr back at 0 for the fairness run.
    do_single(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0); // 2*3 = 6
    do_single(2, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0); // 0*1 = 0
    do_single(1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0, 1'b1); // 2^127^2 overflows
    do_single(0, 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 1'b0, 1'b0); // tie rounds to even
    do_single(3, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, 1'b0); // 2^-126^2 underflows

    // Fairness: all requesters held valid, one grant per cycle in rotation.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = stream_a[i];
      req_b[32*i +: 32] = 32'h4000_0000;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("fair_valid%0d", k), 32'(rsp_valid), 32'd1);
        chk($sformatf("fair_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        chk($sformatf("fair_data%0d", k), rsp_data, stream_p[(k - 2) % 4]);
        chk($sformatf("fair_cnt%0d", k), 32'(op_count), 32'(exp_cnt));
        exp_cnt++;
      end
      tick();
    end
    req_valid = '0;
    for (int k = 8; k < 10; k++) begin
      #1;
      chk($sformatf("fair_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("fair_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
      chk($sformatf("fair_data%0d", k), rsp_data, stream_p[(k - 2) % 4]);
      chk($sformatf("fair_cnt%0d", k), 32'(op_count), 32'(exp_cnt));
      exp_cnt++;
      tick();
    end
    chk("fair_drained", 32'(rsp_valid), 32'd0);
    chk("fair_cnt_end", 32'(op_count), 32'(exp_cnt));

    // Backpressure: downstream stalled 5 cycles -> only two ops enter the pipe.
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 2) begin
        chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'(1 << c));
        chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd0);
      end else begin
        chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
        chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd1);
        chk($sformatf("bp_id%0d", c), 32'(rsp_id), 32'd0);
        chk($sformatf("bp_data%0d", c), rsp_data, stream_p[0]);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_id0", 32'(rsp_id), 32'd0);
    chk("bp_rel_valid0", 32'(rsp_valid), 32'd1);
    tick();
    exp_cnt++;
    chk("bp_rel_valid1", 32'(rsp_valid), 32'd1);
    chk("bp_rel_id1", 32'(rsp_id), 32'd1);
    chk("bp_rel_data1", rsp_data, stream_p[1]);
    tick();
    exp_cnt++;
    chk("bp_rel_done", 32'(rsp_valid), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk("bp_rel_cnt", 32'(op_count), 32'(exp_cnt));

    // Sixteenth op takes the 4-bit counter from 15 to 0.
    chk("wrap_pre", 32'(op_count), 32'd15);
    do_single(2, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 1'b0);
    chk("wrap_zero", 32'(op_count), 32'd0);

    // Reset mid-stream with both stages full.
    rsp_ready = 1'b0;
    req_valid = '1;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_cnt", 32'(op_count), 32'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid0", 32'(rsp_valid), 32'd0);
    tick();
    chk("post_rst_valid1", 32'(rsp_valid), 32'd0);
    chk("post_rst_cnt", 32'(op_count), 32'd0);
    // Pointer restarts at requester 0.
    req_valid = '1;
    #1;
    chk("post_rst_ptr", 32'(req_ready), 32'd1);
    req_valid = '0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
